reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
Multi-round reaction-time controller. It runs ROUNDS trials, each with a random foreperiod followed by a stimulus. It times each response in milliseconds, detects early presses and timeouts, and tracks the best and average times. It sits between the debounced button pulses and LFSR source on one side and the display/LED formatting logic on the other, and outputs binary millisecond results and a status code.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; CLK_HZ/1000 must be an integer ≥ 2.
ROUNDS, 4, trials per session; must be a power of 2 and ≥ 2.
RAND_W, 4, width of the random input.
MIN_DELAY_MS, 1000, minimum foreperiod; must be ≥ 1.
DELAY_STEP_MS, 500, foreperiod increment per random LSB.
TIMEOUT_MS, 1000, saturation point of the reaction count.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start_pulse  in  1  one-cycle pulse; starts a session, advances to the next round, or retries a round
stop_pulse  in  1  one-cycle response pulse
clear_pulse  in  1  one-cycle pulse; abort to IDLE
rand_val  in  RAND_W  free-running random value, sampled in ARM
stim_led  out  1  stimulus; high only in MEASURE
result_ms  out  RES_W  last round result, where RES_W = $clog2(TIMEOUT_MS+1)
best_ms  out  RES_W  minimum result this session
avg_ms  out  RES_W  floor(sum/ROUNDS); valid in DONE
round_idx  out  $clog2(ROUNDS)  current round number
timeout_flag  out  1  last round hit TIMEOUT_MS
status  out  3  reaction_pkg status code of the current state

Behaviour:
- Reset values: state IDLE; all outputs 0 except best_ms, which resets to all-ones. Internal counters, prescaler and sum are 0.
- All outputs are registered or decoded from the registered state. No combinational path exists from inputs to outputs.
- ms tick: prescaler counts 0..DIV-1, where DIV = CLK_HZ/1000. Tick fires when the prescaler equals DIV-1. The prescaler is cleared in ARM and on the DELAY→MEASURE transition.
- clear_pulse has priority over every other input. In any state it moves to IDLE next cycle and clears sum, round_idx, result_ms, timeout_flag, and resets best_ms to all-ones.
- IDLE: start_pulse moves to ARM and clears sum, round_idx and best_ms.
- ARM: lasts one cycle. Loads delay_cnt = MIN_DELAY_MS + rand_val*DELAY_STEP_MS, then moves to DELAY.
- DELAY: delay_cnt decrements on each tick. When the tick takes it 1→0, the next state is MEASURE. Otherwise stop_pulse moves to FAULT (early press). If stop_pulse and the final tick occur in the same cycle, the final tick wins and the stop is ignored.
- MEASURE: stim_led = 1. react_cnt starts at 0, increments on each tick, and saturates at TIMEOUT_MS.
  - On stop_pulse, capture react_cnt (including a tick in the same cycle) into result_ms, clear timeout_flag, and move to RESULT.
  - If react_cnt reaches TIMEOUT_MS, capture TIMEOUT_MS, set timeout_flag, and move to RESULT.
  - On capture, add the result to sum and set best_ms = min(best_ms, result).
- RESULT: start_pulse moves to ARM with round_idx+1 if round_idx < ROUNDS-1; otherwise it moves to DONE.
- DONE: avg_ms = sum >> log2(ROUNDS), registered on entry. The state holds until clear_pulse. start_pulse is ignored.
- FAULT: start_pulse retries the same round (ARM, round_idx unchanged, nothing accumulated). stop_pulse is ignored.
- Sum width is RES_W + $clog2(ROUNDS), so it cannot overflow. Widths of delay_cnt and react_cnt are derived from their maximum values.
- Pulses arriving in states that do not list them are ignored.
- Illegal state encoding: recover to IDLE next cycle with outputs as in reset.
- rst asserted mid-session returns to reset values immediately.

Decomposition:
- reaction_pkg holds:
  - the state enum (IDLE, ARM, DELAY, MEASURE, RESULT, FAULT, DONE), one-hot encoded;
  - the 3-bit status codes: IDLE=0, WAIT=1 for ARM/DELAY, GO=2, RESULT=3, FAULT=4, DONE=5.
- Sub-module ms_tick_gen #(DIV) has inputs clk, rst, sync clr, and output tick. It is also used by display refresh logic.

Test Plan:
All scenarios use CLK_HZ=10000 (DIV=10), MIN_DELAY_MS=2, DELAY_STEP_MS=1, TIMEOUT_MS=50, ROUNDS=4, RAND_W=4.
- Basic round: ARM at cycle t with rand_val=3 → stim_led rises at t+51; stop_pulse at MEASURE cycle 123 → result_ms=12, status=3, timeout_flag=0.
- Early press: stop_pulse 20 cycles into DELAY → status=4 (FAULT), stim_led=0, sum unchanged; start_pulse → ARM with round_idx unchanged.
- Timeout: no stop in MEASURE → RESULT after 500 cycles; result_ms=50, timeout_flag=1.
- Full session: results 10, 20, 30, 41 → DONE with status=5, avg_ms=25, best_ms=10, round_idx=3; start_pulse in DONE has no effect.
- Simultaneous events: stop_pulse on the cycle of the final DELAY tick → MEASURE, not FAULT. clear_pulse together with start_pulse in RESULT → IDLE.
- rst asserted mid-MEASURE of round 2 → all outputs at reset values on the next edge, and best_ms is all-ones.

Source files
------------

// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared types for the reaction-time controller: one-hot FSM states and
// the 3-bit status codes consumed by the display/LED formatting logic.
package reaction_timer_ctrl_pkg;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b000_0001,
        S_ARM     = 7'b000_0010,
        S_DELAY   = 7'b000_0100,
        S_MEASURE = 7'b000_1000,
        S_RESULT  = 7'b001_0000,
        S_FAULT   = 7'b010_0000,
        S_DONE    = 7'b100_0000
    } state_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_GO     = 3'd2,
        ST_RESULT = 3'd3,
        ST_FAULT  = 3'd4,
        ST_DONE   = 3'd5
    } status_e;

    // ARM and DELAY both look like "waiting" to the user; any illegal
    // encoding reports IDLE, matching what the FSM recovers to.
    function automatic status_e status_of(state_e s);
        case (s)
            S_IDLE:         return ST_IDLE;
            S_ARM, S_DELAY: return ST_WAIT;
            S_MEASURE:      return ST_GO;
            S_RESULT:       return ST_RESULT;
            S_FAULT:        return ST_FAULT;
            S_DONE:         return ST_DONE;
            default:        return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Pulse inputs, random source and result outputs of the reaction-time
// controller. master = button/LFSR/display side, slave = controller.
interface reaction_timer_ctrl_if #(
    parameter int unsigned RAND_W = 4,
    parameter int unsigned RES_W  = 10,
    parameter int unsigned IDX_W  = 2
);
    logic              start_pulse;
    logic              stop_pulse;
    logic              clear_pulse;
    logic [RAND_W-1:0] rand_val;
    logic              stim_led;
    logic [RES_W-1:0]  result_ms;
    logic [RES_W-1:0]  best_ms;
    logic [RES_W-1:0]  avg_ms;
    logic [IDX_W-1:0]  round_idx;
    logic              timeout_flag;
    logic [2:0]        status;

    modport master (
        output start_pulse, stop_pulse, clear_pulse, rand_val,
        input  stim_led, result_ms, best_ms, avg_ms, round_idx, timeout_flag, status
    );

    modport slave (
        input  start_pulse, stop_pulse, clear_pulse, rand_val,
        output stim_led, result_ms, best_ms, avg_ms, round_idx, timeout_flag, status
    );
endinterface

// File: rtl/reaction_timer_ctrl_ms_tick_gen.sv
// Millisecond tick: free-running prescaler 0..DIV-1, tick on the last
// count. A synchronous clear restarts the millisecond from zero.
module ms_tick_gen #(
    parameter int unsigned DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int unsigned     PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    assign tick = (pre_q == LAST);

    // next prescaler count: wrap after the tick, restart on clear
    always_comb begin
        pre_d = pre_q + PW'(1);
        if (clr || tick) pre_d = '0;
    end

    // prescaler register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
    end
endmodule

// File: rtl/reaction_timer_ctrl.sv
// Multi-round reaction-time controller: random foreperiod, stimulus,
// millisecond response timing, early-press and timeout detection,
// best and average tracking across ROUNDS trials.
//
// state   | meaning
// IDLE    | no session; start begins round 0
// ARM     | one cycle; load foreperiod from rand_val
// DELAY   | foreperiod countdown; a press here is early
// MEASURE | stimulus on; counting response milliseconds
// RESULT  | round captured; start goes to next round or DONE
// FAULT   | early press; start retries the same round
// DONE    | session complete; average valid, wait for clear
module reaction_timer_ctrl
    import reaction_timer_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned ROUNDS        = 4,
    parameter int unsigned RAND_W        = 4,
    parameter int unsigned MIN_DELAY_MS  = 1000,
    parameter int unsigned DELAY_STEP_MS = 500,
    parameter int unsigned TIMEOUT_MS    = 1000
) (
    input logic                  clk,
    input logic                  rst,
    reaction_timer_ctrl_if.slave ctrl_if
);
    localparam int unsigned DIV     = CLK_HZ / 1000;
    localparam int unsigned RES_W   = $clog2(TIMEOUT_MS + 1);
    localparam int unsigned IDX_W   = $clog2(ROUNDS);
    localparam int unsigned SUM_W   = RES_W + IDX_W;
    localparam int unsigned DLY_MAX = MIN_DELAY_MS + ((2 ** RAND_W) - 1) * DELAY_STEP_MS;
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
    localparam logic [RES_W-1:0] TMO = RES_W'(TIMEOUT_MS);

    state_e            state_q;
    logic [DLY_W-1:0]  delay_q;
    logic [RES_W-1:0]  react_q;
    logic [RES_W-1:0]  react_d;
    logic [RES_W-1:0]  result_q;
    logic [RES_W-1:0]  best_q;
    logic [RES_W-1:0]  avg_q;
    logic [SUM_W-1:0]  sum_q;
    logic [IDX_W-1:0]  idx_q;
    logic              tflag_q;
    logic              tick;
    logic              tick_clr;
    logic              final_tick;
    logic              capture;
    logic [DLY_W-1:0]  delay_load;

    // restart the millisecond when the foreperiod starts and when the
    // stimulus appears, so both intervals are whole milliseconds
    ms_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    assign delay_load = DLY_W'(MIN_DELAY_MS) + DLY_W'(ctrl_if.rand_val) * DLY_W'(DELAY_STEP_MS);
    assign final_tick = (state_q == S_DELAY) && tick && (delay_q == DLY_W'(1));
    assign tick_clr   = (state_q == S_ARM) || final_tick;
    // response count including a tick in this cycle, saturating at timeout
    assign react_d    = (tick && (react_q != TMO)) ? react_q + RES_W'(1) : react_q;
    assign capture    = ctrl_if.stop_pulse || (react_d == TMO);

    assign ctrl_if.stim_led     = (state_q == S_MEASURE);
    assign ctrl_if.status       = status_of(state_q);
    assign ctrl_if.result_ms    = result_q;
    assign ctrl_if.best_ms      = best_q;
    assign ctrl_if.avg_ms       = avg_q;
    assign ctrl_if.round_idx    = idx_q;
    assign ctrl_if.timeout_flag = tflag_q;

    // session FSM with its counters and result registers; clear overrides all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            delay_q  <= '0;
            react_q  <= '0;
            result_q <= '0;
            best_q   <= '1;
            avg_q    <= '0;
            sum_q    <= '0;
            idx_q    <= '0;
            tflag_q  <= 1'b0;
        end else if (ctrl_if.clear_pulse) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            tflag_q  <= 1'b0;
            best_q   <= '1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_if.start_pulse) begin
                        state_q <= S_ARM;
                        sum_q   <= '0;
                        idx_q   <= '0;
                        best_q  <= '1;
                    end
                end
                S_ARM: begin
                    delay_q <= delay_load;
                    react_q <= '0;
                    state_q <= S_DELAY;
                end
                S_DELAY: begin
                    if (tick && (delay_q != '0)) delay_q <= delay_q - DLY_W'(1);
                    if (final_tick)                  state_q <= S_MEASURE;
                    else if (ctrl_if.stop_pulse)     state_q <= S_FAULT;
                end
                S_MEASURE: begin
                    react_q <= react_d;
                    if (capture) begin
                        result_q <= react_d;
                        tflag_q  <= ~ctrl_if.stop_pulse;
                        sum_q    <= sum_q + SUM_W'(react_d);
                        if (react_d < best_q) best_q <= react_d;
                        state_q  <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (ctrl_if.start_pulse) begin
                        if (idx_q != {IDX_W{1'b1}}) begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= S_ARM;
                        end else begin
                            avg_q   <= RES_W'(sum_q >> IDX_W);
                            state_q <= S_DONE;
                        end
                    end
                end
                S_FAULT: begin
                    if (ctrl_if.start_pulse) state_q <= S_ARM;
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    delay_q  <= '0;
                    react_q  <= '0;
                    result_q <= '0;
                    best_q   <= '1;
                    avg_q    <= '0;
                    sum_q    <= '0;
                    idx_q    <= '0;
                    tflag_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl: each round pushes its expected
// RESULT snapshot when the response (or lack of one) is driven, and pops it
// when the controller reaches RESULT.
module tb_reaction_timer_ctrl;
    localparam int CLK_HZ        = 10000;
    localparam int ROUNDS        = 4;
    localparam int RAND_W        = 4;
    localparam int MIN_DELAY_MS  = 2;
    localparam int DELAY_STEP_MS = 1;
    localparam int TIMEOUT_MS    = 50;
    localparam int DIV           = CLK_HZ / 1000;
    localparam int RES_W         = 6;
    localparam int IDX_W         = 2;
    localparam int BEST_RST      = (1 << RES_W) - 1;

    typedef struct {
        int status;
        int result;
        int tflag;
        int best;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_sum   = 0;
    int   m_best  = BEST_RST;
    int   m_idx   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reaction_timer_ctrl_if #(.RAND_W(RAND_W), .RES_W(RES_W), .IDX_W(IDX_W)) bus ();

    reaction_timer_ctrl #(
        .CLK_HZ        (CLK_HZ),
        .ROUNDS        (ROUNDS),
        .RAND_W        (RAND_W),
        .MIN_DELAY_MS  (MIN_DELAY_MS),
        .DELAY_STEP_MS (DELAY_STEP_MS),
        .TIMEOUT_MS    (TIMEOUT_MS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_vals(input string pfx);
        chk({pfx, "_status"}, bus.status, 0);
        chk({pfx, "_stim"},   bus.stim_led, 0);
        chk({pfx, "_result"}, bus.result_ms, 0);
        chk({pfx, "_best"},   bus.best_ms, BEST_RST);
        chk({pfx, "_avg"},    bus.avg_ms, 0);
        chk({pfx, "_idx"},    bus.round_idx, 0);
        chk({pfx, "_tflag"},  bus.timeout_flag, 0);
    endtask

    task automatic pulse_start();
        bus.start_pulse = 1'b1;
        @(negedge clk);
        bus.start_pulse = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop_pulse = 1'b1;
        @(negedge clk);
        bus.stop_pulse = 1'b0;
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_pop: observed empty queue, expected a pending round");
            return;
        end
        e = sb.pop_front();
        chk("res_status", bus.status, e.status);
        chk("res_result", bus.result_ms, e.result);
        chk("res_tflag",  bus.timeout_flag, e.tflag);
        chk("res_best",   bus.best_ms, e.best);
        chk("res_idx",    bus.round_idx, e.idx);
    endtask

    // One round from IDLE/RESULT/FAULT. stop_c = MEASURE cycle of the press,
    // negative for no press (timeout).
    task automatic run_round(input int rv, input int stop_c);
        int   k;
        int   r;
        exp_t e;
        if (bus.status == 3'd0) begin
            m_idx = 0; m_sum = 0; m_best = BEST_RST;
        end else if (bus.status == 3'd3) begin
            m_idx++;
        end
        bus.rand_val = RAND_W'(rv);
        pulse_start();
        chk("arm_status", bus.status, 1);
        chk("arm_idx", bus.round_idx, m_idx);
        k = 0;
        while (!bus.stim_led && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("stim_rise", k, (MIN_DELAY_MS + rv * DELAY_STEP_MS) * DIV + 1);
        if (stop_c < 0) r = TIMEOUT_MS;
        else            r = ((stop_c + 1) / DIV > TIMEOUT_MS) ? TIMEOUT_MS : (stop_c + 1) / DIV;
        m_sum += r;
        if (r < m_best) m_best = r;
        e.status = 3;
        e.result = r;
        e.tflag  = (stop_c < 0) ? 1 : 0;
        e.best   = m_best;
        e.idx    = m_idx;
        sb.push_back(e);
        if (stop_c >= 0) begin
            repeat (stop_c) @(negedge clk);
            pulse_stop();
        end else begin
            k = 0;
            while (bus.status != 3'd3 && k < 1000) begin
                @(negedge clk);
                k++;
            end
            chk("timeout_lat", k, TIMEOUT_MS * DIV);
        end
        sb_check();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish by %0t, expected earlier finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start_pulse = 1'b0;
        bus.stop_pulse  = 1'b0;
        bus.clear_pulse = 1'b0;
        bus.rand_val    = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_rst_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_status", bus.status, 0);

        // session 1: basic round, timeout round, simultaneous event, reset
        run_round(3, 123);
        run_round(0, -1);
        m_idx++;
        bus.rand_val = RAND_W'(5);
        pulse_start();
        chk("arm_idx", bus.round_idx, m_idx);
        repeat (70) @(negedge clk);
        pulse_stop();
        chk("simul_status", bus.status, 2);
        chk("simul_stim", bus.stim_led, 1);
        repeat (37) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_rst_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // session 2: full session with an early press before round 2
        run_round(1, 100);
        run_round(2, 200);
        m_idx++;
        bus.rand_val = RAND_W'(3);
        pulse_start();
        chk("arm_idx", bus.round_idx, m_idx);
        repeat (20) @(negedge clk);
        pulse_stop();
        chk("early_status", bus.status, 4);
        chk("early_stim", bus.stim_led, 0);
        pulse_stop();
        chk("fault_stop_ign", bus.status, 4);
        run_round(7, 300);
        run_round(15, 410);
        pulse_start();
        chk("done_status", bus.status, 5);
        chk("done_avg", bus.avg_ms, m_sum / ROUNDS);
        chk("done_best", bus.best_ms, m_best);
        chk("done_idx", bus.round_idx, ROUNDS - 1);
        chk("done_result", bus.result_ms, 41);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("done_hold_status", bus.status, 5);
        chk("done_hold_idx", bus.round_idx, ROUNDS - 1);
        chk("done_hold_avg", bus.avg_ms, 25);

        // session 3: clear from DONE, then clear racing start in RESULT
        bus.clear_pulse = 1'b1;
        @(negedge clk);
        bus.clear_pulse = 1'b0;
        chk("clr_status", bus.status, 0);
        chk("clr_best", bus.best_ms, BEST_RST);
        chk("clr_idx", bus.round_idx, 0);
        chk("clr_result", bus.result_ms, 0);
        run_round(2, 55);
        bus.clear_pulse = 1'b1;
        bus.start_pulse = 1'b1;
        @(negedge clk);
        bus.clear_pulse = 1'b0;
        bus.start_pulse = 1'b0;
        chk("clrstart_status", bus.status, 0);
        chk("clrstart_result", bus.result_ms, 0);
        chk("clrstart_best", bus.best_ms, BEST_RST);
        chk("clrstart_idx", bus.round_idx, 0);
        chk("clrstart_tflag", bus.timeout_flag, 0);
        @(negedge clk);
        chk("clrstart_hold", bus.status, 0);

        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
